// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit LCD interface: reader states, default
// phase timings (50 MHz cycles) and register-select encodings used by both data paths.
package lcd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StE1Hi,
        StE1Lo,
        StE2Hi,
        StE2Lo,
        StDone
    } rd_state_e;

    localparam int unsigned T_AS_DEF     = 2;
    localparam int unsigned T_EH_DEF     = 13;
    localparam int unsigned T_EL_DEF     = 37;
    localparam int unsigned POLL_MAX_DEF = 255;

    // Phase timer width; must hold the largest phase length minus one.
    localparam int unsigned CNT_W = 8;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    // A phase of n cycles is loaded as n-1 so that done rises on its last cycle.
    function automatic logic [CNT_W-1:0] phase_load(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter shared by all reader phases; done is high while the count is zero.
module lcd_phase_timer
    import lcd_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// 4-bit mode read engine for the HD44780 LCD: two E strobes per byte, high nibble first.
// Define LCD_BUSY_POLL_EN to add the busy-flag poll loop (poll_req, lcd_idle, poll_err).
module lcd_bus_reader
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS = T_AS_DEF,
    parameter int unsigned T_EH = T_EH_DEF,
    parameter int unsigned T_EL = T_EL_DEF
`ifdef LCD_BUSY_POLL_EN
    ,
    parameter int unsigned POLL_MAX = POLL_MAX_DEF
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_req,
    input  logic       rd_rs,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_active,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    input  logic [3:0] lcd_db_in
`ifdef LCD_BUSY_POLL_EN
    ,
    input  logic       poll_req,
    output logic       lcd_idle,
    output logic       poll_err
`endif
);

    rd_state_e        state_q, state_d;
    logic             rs_q, rs_d;
    logic [3:0]       hi_q, hi_d, lo_q, lo_d;
    logic [7:0]       data_q, data_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic             start;

`ifdef LCD_BUSY_POLL_EN
    logic        poll_q, poll_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    assign start    = rd_req | poll_req;
    assign poll_err = err_q;
`else
    assign start = rd_req;
`endif

    lcd_phase_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        data_d   = data_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef LCD_BUSY_POLL_EN
        poll_d   = poll_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        lcd_idle = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rs_d     = rd_rs;
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(T_AS);
                    state_d  = StSetup;
`ifdef LCD_BUSY_POLL_EN
                    // A poll takes priority over a simultaneous single read.
                    if (poll_req) begin
                        rs_d   = RS_CMD;
                        poll_d = 1'b1;
                        err_d  = 1'b0;
                        cnt_d  = '0;
                    end
`endif
                end
            end
            StSetup: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(T_EH);
                    state_d  = StE1Hi;
                end
            end
            StE1Hi: begin
                if (tmr_done) begin
                    hi_d     = lcd_db_in;
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(T_EL);
                    state_d  = StE1Lo;
                end
            end
            StE1Lo: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(T_EH);
                    state_d  = StE2Hi;
                end
            end
            StE2Hi: begin
                if (tmr_done) begin
                    lo_d     = lcd_db_in;
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(T_EL);
                    state_d  = StE2Lo;
                end
            end
            StE2Lo: begin
                if (tmr_done) begin
                    data_d  = {hi_q, lo_q};
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                rs_d    = RS_CMD;
`ifdef LCD_BUSY_POLL_EN
                if (poll_q) begin
                    cnt_d = cnt_q + 16'd1;
                    if (!data_q[7]) begin
                        lcd_idle = 1'b1;
                        poll_d   = 1'b0;
                    end else if ((cnt_q + 16'd1) >= 16'(POLL_MAX)) begin
                        err_d  = 1'b1;
                        poll_d = 1'b0;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = phase_load(T_AS);
                        state_d  = StSetup;
                    end
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            rs_q    <= RS_CMD;
            hi_q    <= '0;
            lo_q    <= '0;
            data_q  <= '0;
`ifdef LCD_BUSY_POLL_EN
            poll_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
`ifdef LCD_BUSY_POLL_EN
            poll_q  <= poll_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Outputs decode straight from state so an async reset drops E and RW at once.
    assign rd_ready  = (state_q == StIdle);
    assign rd_active = ~rd_ready;
    assign rd_valid  = (state_q == StDone);
    assign rd_data   = data_q;
    assign lcd_rw    = rd_active;
    assign lcd_rs    = rd_active & rs_q;
    assign lcd_e     = (state_q == StE1Hi) | (state_q == StE2Hi);

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Randomised bench for lcd_bus_reader against a behavioural HD44780 read model.
// Poll-loop checks are compiled in when LCD_BUSY_POLL_EN is defined.
module tb_lcd_bus_reader;
    import lcd_pkg::*;

    localparam int unsigned TAS = 2;
    localparam int unsigned TEH = 13;
    localparam int unsigned TEL = 37;
    localparam int unsigned LAT = TAS + 2 * TEH + 2 * TEL + 1;
`ifdef LCD_BUSY_POLL_EN
    localparam int unsigned PMAX = 4;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rd_req;
    logic       rd_rs;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_active;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [3:0] lcd_db_in;
`ifdef LCD_BUSY_POLL_EN
    logic       poll_req;
    logic       lcd_idle;
    logic       poll_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lcd_bus_reader #(
        .T_AS(TAS),
        .T_EH(TEH),
        .T_EL(TEL)
`ifdef LCD_BUSY_POLL_EN
        ,
        .POLL_MAX(PMAX)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_req   (rd_req),
        .rd_rs    (rd_rs),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_active(rd_active),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_db_in(lcd_db_in)
`ifdef LCD_BUSY_POLL_EN
        ,
        .poll_req (poll_req),
        .lcd_idle (lcd_idle),
        .poll_err (poll_err)
`endif
    );

    // LCD model: each read returns the head of byte_q, high nibble on the first E pulse.
    // The bus carries junk while E is low and for the first cycles of E high (tDDR).
    logic [7:0] byte_q[$];
    logic [7:0] cur_byte = 8'h00;
    bit         nib_sel  = 1'b0;
    int         e_hi_cnt = 0;
    logic [3:0] garbage  = 4'h0;

    function automatic void model_load();
        cur_byte = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
    endfunction

    always @(negedge lcd_e) begin
        if (!reset) begin
            if (nib_sel) begin
                if (byte_q.size() != 0) void'(byte_q.pop_front());
                model_load();
            end
            nib_sel = ~nib_sel;
        end
    end

    always @(posedge reset) nib_sel = 1'b0;

    always @(posedge clk) e_hi_cnt <= lcd_e ? e_hi_cnt + 1 : 0;
    always @(negedge clk) garbage <= 4'($urandom);

    assign lcd_db_in = (lcd_e && e_hi_cnt >= 8) ? (nib_sel ? cur_byte[3:0] : cur_byte[7:4])
                                                : garbage;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_read(input logic rs, input logic [7:0] b, input bit mid_req);
        int cyc;
        int w;
        int w1;
        int w2;
        int pulses;
        int ctrl_bad;
        int valids;
        bit got;
        byte_q.push_back(b);
        model_load();
        cyc = 0;
        while (!rd_ready && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("ready_before_req", rd_ready, 1);
        rd_req = 1'b1;
        rd_rs  = rs;
        @(negedge clk);
        rd_req = 1'b0;
        rd_rs  = 1'($urandom);
        cyc = 1; w = 0; w1 = 0; w2 = 0; pulses = 0; ctrl_bad = 0; got = 1'b0;
        while (cyc <= int'(LAT) + 20) begin
            if (lcd_e) begin
                w++;
                if (lcd_rs !== rs || lcd_rw !== 1'b1 || rd_active !== 1'b1) ctrl_bad++;
            end else if (w > 0) begin
                pulses++;
                if (pulses == 1) w1 = w;
                else w2 = w;
                w = 0;
            end
            rd_req = (mid_req && cyc == 50);
            if (rd_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        rd_req = 1'b0;
        check_eq("valid_seen", got, 1);
        check_eq("latency", cyc, LAT);
        check_eq("rd_data", rd_data, b);
        check_eq("e_pulses", pulses, 2);
        check_eq("e1_width", w1, TEH);
        check_eq("e2_width", w2, TEH);
        check_eq("ctrl_stable_in_e", ctrl_bad, 0);
        check_eq("rs_in_done", lcd_rs, rs);
        @(negedge clk);
        check_eq("ready_after", rd_ready, 1);
        check_eq("valid_one_cycle", rd_valid, 0);
        check_eq("active_after", rd_active, 0);
        check_eq("rw_after", lcd_rw, 0);
        check_eq("rs_after", lcd_rs, 0);
        valids = 0;
        for (int i = 0; i < int'(LAT) + 10; i++) begin
            @(negedge clk);
            if (rd_valid) valids++;
        end
        check_eq("no_extra_valid", valids, 0);
        check_eq("data_held", rd_data, b);
    endtask

    task automatic do_reset_abort();
        int cyc;
        int valids;
        byte_q.push_back(8'($urandom));
        model_load();
        rd_req = 1'b1;
        rd_rs  = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        cyc = 0;
        while (!lcd_e && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("e1_reached", lcd_e, 1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_e_low", lcd_e, 0);
        check_eq("rst_rw_low", lcd_rw, 0);
        check_eq("rst_active_low", rd_active, 0);
        check_eq("rst_ready", rd_ready, 1);
        check_eq("rst_data", rd_data, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        byte_q.delete();
        model_load();
        valids = 0;
        for (int i = 0; i < int'(LAT) + 10; i++) begin
            @(negedge clk);
            if (rd_valid) valids++;
        end
        check_eq("no_valid_after_abort", valids, 0);
    endtask

`ifdef LCD_BUSY_POLL_EN
    task automatic do_poll(input int busy_reads, input bit ends_idle);
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int cyc;
        int valids;
        int idles;
        int rs_bad;
        int data_bad;
        for (int i = 0; i < busy_reads; i++) begin
            b = 8'h80 | 8'($urandom_range(0, 127));
            byte_q.push_back(b);
            exp_q.push_back(b);
        end
        if (ends_idle) begin
            byte_q.push_back(8'h0C);
            exp_q.push_back(8'h0C);
        end
        model_load();
        // Simultaneous single read request must lose to the poll.
        poll_req = 1'b1;
        rd_req   = 1'b1;
        rd_rs    = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        rd_req   = 1'b0;
        check_eq("poll_err_cleared", poll_err, 0);
        cyc = 1; valids = 0; idles = 0; rs_bad = 0; data_bad = 0;
        while (cyc < 8 * int'(LAT)) begin
            if (lcd_e && lcd_rs !== 1'b0) rs_bad++;
            if (lcd_idle) idles++;
            if (rd_valid) begin
                valids++;
                if (exp_q.size() == 0 || rd_data !== exp_q[0]) data_bad++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (rd_ready) break;
            @(negedge clk);
            cyc++;
        end
        check_eq("poll_done", rd_ready, 1);
        check_eq("poll_valids", valids, ends_idle ? busy_reads + 1 : int'(PMAX));
        check_eq("poll_idles", idles, ends_idle ? 1 : 0);
        check_eq("poll_err", poll_err, ends_idle ? 0 : 1);
        check_eq("poll_rs_status", rs_bad, 0);
        check_eq("poll_data", data_bad, 0);
        byte_q.delete();
        model_load();
    endtask
`endif

    initial begin
        reset  = 1'b1;
        rd_req = 1'b0;
        rd_rs  = 1'b0;
`ifdef LCD_BUSY_POLL_EN
        poll_req = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_ready", rd_ready, 1);
        check_eq("rst_valid", rd_valid, 0);
        check_eq("rst_e", lcd_e, 0);
        check_eq("rst_rw", lcd_rw, 0);
        check_eq("rst_rs", lcd_rs, 0);
        check_eq("rst_active", rd_active, 0);
        check_eq("rst_data", rd_data, 8'h00);
`ifdef LCD_BUSY_POLL_EN
        check_eq("rst_idle", lcd_idle, 0);
        check_eq("rst_poll_err", poll_err, 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        do_read(RS_CMD, 8'hA5, 1'b0);
        do_read(RS_DATA, 8'h41, 1'b0);
        do_read(1'($urandom), 8'($urandom), 1'b1);
        do_reset_abort();
        do_read(RS_DATA, 8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_read(1'($urandom), 8'($urandom), 1'($urandom));
        end

`ifdef LCD_BUSY_POLL_EN
        do_poll(3, 1'b1);
        do_poll(PMAX + 2, 1'b0);
        do_poll(0, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
